// File: rtl/nn_pkg.sv
// Shared widths and saturation constants for the neuron output stage.
package nn_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned ACC_W          = 2 * DEF_DATA_WIDTH;

  localparam logic [DEF_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
  localparam logic [DEF_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/requant_sat.sv
// Combinational round-half-up, arithmetic shift, saturate and optional ReLU
// from a 2*DATA_WIDTH accumulator down to DATA_WIDTH.
module requant_sat #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_SHIFT = 16,
  parameter bit          RELU_EN    = 1'b1
) (
  input  logic [2*DATA_WIDTH-1:0] acc_i,
  output logic [DATA_WIDTH-1:0]   result_c_o,
  output logic                    sat_c_o
);

  localparam int unsigned ACC_W = 2 * DATA_WIDTH;
  localparam int unsigned RW    = ACC_W + 1;

  localparam logic [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic signed [RW-1:0] MAX_EXT =
    {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_EXT =
    {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [RW-1:0] rounded;
  logic signed [RW-1:0] shifted;

  // One extra bit of headroom so adding the rounding half never wraps.
  assign rounded = $signed({acc_i[ACC_W-1], acc_i}) + $signed(HALF);
  assign shifted = rounded >>> FRAC_SHIFT;

  always_comb begin
    sat_c_o    = 1'b0;
    result_c_o = shifted[DATA_WIDTH-1:0];
    if (shifted > MAX_EXT) begin
      result_c_o = OUT_MAX;
      sat_c_o    = 1'b1;
    end else if (shifted < MIN_EXT) begin
      result_c_o = OUT_MIN;
      sat_c_o    = 1'b1;
    end
    // ReLU leaves the saturation flag untouched.
    if (RELU_EN && result_c_o[DATA_WIDTH-1]) begin
      result_c_o = '0;
    end
  end

endmodule

// File: rtl/nn_acc_requant.sv
// Neuron output stage: frame the accumulator stream, requantize the last beat
// of each frame and buffer results in a 2-entry FIFO towards downstream.
module nn_acc_requant
  import nn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned N_INPUTS   = 16,
  parameter int unsigned FRAC_SHIFT = 16,
  parameter bit          RELU_EN    = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_axis_tvalid,
  input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    overrun,
  output logic [15:0]             result_count
);

  localparam int unsigned IN_W  = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int unsigned ENT_W = DATA_WIDTH + 1;

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]  s1_data_q, s1_data_d;

  logic [ENT_W-1:0] mem_q [2];
  logic [ENT_W-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      res_cnt_q, res_cnt_d;

  logic [DATA_WIDTH-1:0] rq_data_c;
  logic                  rq_sat_c;
  logic                  beat_last;
  logic                  deq;
  logic                  enq_ok;

  requant_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT),
    .RELU_EN    (RELU_EN)
  ) u_requant_sat (
    .acc_i      (s1_data_q),
    .result_c_o (rq_data_c),
    .sat_c_o    (rq_sat_c)
  );

  assign beat_last = (beat_cnt_q == CNT_W'(N_INPUTS - 1));
  assign deq       = (count_q != 2'd0) && m_axis_tready;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign enq_ok    = s1_valid_q && ((count_q != 2'd2) || deq);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    s1_valid_d = 1'b0;
    s1_data_d  = s1_data_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q ^ enq_ok;
    rd_ptr_d   = rd_ptr_q ^ deq;
    count_d    = count_q + 2'(enq_ok) - 2'(deq);
    overrun_d  = overrun_q | (s1_valid_q & ~enq_ok);
    res_cnt_d  = res_cnt_q + 16'(deq);

    if (s_axis_tvalid) begin
      if (beat_last) begin
        s1_data_d  = s_axis_tdata;
        s1_valid_d = 1'b1;
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end

    if (enq_ok) begin
      mem_d[wr_ptr_q] = {rq_sat_c, rq_data_c};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      overrun_q  <= 1'b0;
      res_cnt_q  <= 16'd0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      res_cnt_q  <= res_cnt_d;
    end
  end

  assign m_axis_tdata  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign m_axis_tuser  = mem_q[rd_ptr_q][DATA_WIDTH];
  assign m_axis_tvalid = (count_q != 2'd0);
  assign overrun       = overrun_q;
  assign result_count  = res_cnt_q;

endmodule

// File: tb/tb_nn_acc_requant.sv
// Directed bench for nn_acc_requant: two instances differing only in RELU_EN.
module tb_nn_acc_requant;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [63:0] s_data;
  logic        m_ready;

  logic [31:0] a_data, b_data;
  logic        a_user, b_user, a_valid, b_valid, a_ovr, b_ovr;
  logic [15:0] a_cnt, b_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nn_acc_requant #(.DATA_WIDTH(32), .N_INPUTS(4), .FRAC_SHIFT(16), .RELU_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .s_axis_tvalid(s_valid), .s_axis_tdata(s_data),
    .m_axis_tdata(a_data), .m_axis_tuser(a_user), .m_axis_tvalid(a_valid),
    .m_axis_tready(m_ready), .overrun(a_ovr), .result_count(a_cnt));

  nn_acc_requant #(.DATA_WIDTH(32), .N_INPUTS(4), .FRAC_SHIFT(16), .RELU_EN(1'b0)) dut_norelu (
    .clk(clk), .reset(reset), .s_axis_tvalid(s_valid), .s_axis_tdata(s_data),
    .m_axis_tdata(b_data), .m_axis_tuser(b_user), .m_axis_tvalid(b_valid),
    .m_axis_tready(m_ready), .overrun(b_ovr), .result_count(b_cnt));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Three filler beats then the frame's last beat; returns one negedge after it.
  task automatic send_frame(input logic [63:0] last);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = (i == 3) ? last : 64'h0000_0000_0009_0000;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_data",  64'(a_data),  64'd0);
    chk("rst_user",  64'(a_user),  64'd0);
    chk("rst_ovr",   64'(a_ovr),   64'd0);
    chk("rst_cnt",   64'(a_cnt),   64'd0);
    chk("rst_b_all", {a_cnt, b_cnt, 29'd0, b_valid, b_ovr, b_user}, 64'd0);
    reset = 1'b0;

    // Rounding and 2-cycle latency
    send_frame(64'h0000_0003_0001_8000);
    chk("lat_not_yet", 64'(a_valid), 64'd0);
    @(negedge clk);
    chk("lat_valid", 64'(a_valid), 64'd1);
    chk("rnd_data",  64'(a_data),  64'h0003_0002);
    chk("rnd_user",  64'(a_user),  64'd0);
    chk("rnd_b",     64'(b_data),  64'h0003_0002);
    @(negedge clk);
    chk("rnd_drain", 64'(a_valid), 64'd0);
    chk("rnd_cnt",   64'(a_cnt),   64'd1);

    // Positive saturation
    send_frame(64'h0001_0000_0000_0000);
    @(negedge clk);
    chk("psat_data", 64'(a_data), 64'h7FFF_FFFF);
    chk("psat_user", 64'(a_user), 64'd1);
    @(negedge clk);

    // Negative value, with and without ReLU
    send_frame(64'hFFFF_FFFF_FFFB_0000);
    @(negedge clk);
    chk("neg_relu_data", 64'(a_data), 64'h0);
    chk("neg_relu_user", 64'(a_user), 64'd0);
    chk("neg_raw_data",  64'(b_data), 64'hFFFF_FFFB);
    chk("neg_raw_user",  64'(b_user), 64'd0);
    @(negedge clk);

    // Negative saturation: ReLU keeps the saturation flag
    send_frame(64'h8000_0000_0000_0000);
    @(negedge clk);
    chk("nsat_relu_data", 64'(a_data), 64'h0);
    chk("nsat_relu_user", 64'(a_user), 64'd1);
    chk("nsat_raw_data",  64'(b_data), 64'h8000_0000);
    chk("nsat_raw_user",  64'(b_user), 64'd1);
    @(negedge clk);
    chk("cnt_four", 64'(a_cnt), 64'd4);

    // Backpressure: third result dropped
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ready = 1'b0;
    send_frame(64'h0000_0011_0000_0000);
    send_frame(64'h0000_0022_0000_0000);
    repeat (2) @(negedge clk);
    chk("bp_ovr_clear", 64'(a_ovr),  64'd0);
    chk("bp_head_a",    64'(a_data), 64'h0011_0000);
    send_frame(64'h0000_0033_0000_0000);
    repeat (2) @(negedge clk);
    chk("bp_ovr_set",   64'(a_ovr),   64'd1);
    chk("bp_hold_a",    64'(a_data),  64'h0011_0000);
    chk("bp_valid",     64'(a_valid), 64'd1);
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_b",  64'(a_data),  64'h0022_0000);
    @(negedge clk);
    chk("bp_empty",     64'(a_valid), 64'd0);
    chk("bp_cnt",       64'(a_cnt),   64'd2);

    // Reset mid-frame discards partial beats
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 64'h0000_7777_0000_0000;
    end
    @(negedge clk);
    s_valid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_ovr", 64'(a_ovr), 64'd0);
    chk("mid_rst_cnt", 64'(a_cnt), 64'd0);
    send_frame(64'h0000_0000_0005_0000);
    @(negedge clk);
    chk("mid_valid", 64'(a_valid), 64'd1);
    chk("mid_data",  64'(a_data),  64'h5);
    repeat (3) @(negedge clk);
    chk("mid_single", 64'(a_valid), 64'd0);
    chk("mid_cnt",    64'(a_cnt),   64'd1);

    // Full FIFO with enqueue and dequeue in the same cycle
    m_ready = 1'b0;
    send_frame(64'h0000_0041_0000_0000);
    send_frame(64'h0000_0042_0000_0000);
    send_frame(64'h0000_0043_0000_0000);
    chk("sim_head_a", 64'(a_data), 64'h0041_0000);
    m_ready = 1'b1;
    @(negedge clk);
    chk("sim_no_ovr", 64'(a_ovr),  64'd0);
    chk("sim_b",      64'(a_data), 64'h0042_0000);
    @(negedge clk);
    chk("sim_c",      64'(a_data), 64'h0043_0000);
    @(negedge clk);
    chk("sim_empty",  64'(a_valid), 64'd0);
    chk("sim_cnt",    64'(a_cnt),   64'd4);
    chk("sim_ovr_end", 64'(a_ovr),  64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nn_acc_requant.md
# nn_acc_requant

Output stage of a neuron datapath: consumes the 2·DATA_WIDTH accumulator stream from the `mul` MAC block. It counts valid beats into frames of N_INPUTS samples and takes the last beat of each frame as the neuron pre-activation. That value is rounded, shifted, saturated and optionally rectified back to DATA_WIDTH. The result is presented on a valid/ready output stream with a 2-entry buffer, because the MAC side has no backpressure.

## Interface
- DATA_WIDTH, 32: width of the output word; the input word is 2·DATA_WIDTH.
- N_INPUTS, 16: valid input beats per neuron frame; must be ≥ 1.
- FRAC_SHIFT, 16: arithmetic right shift applied to the accumulator; range 1..2·DATA_WIDTH-1.
- RELU_EN, 1: 1 clamps negative results to 0; 0 passes them through.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- s_axis_tvalid  in  1  input beat valid; there is no ready, so every valid beat is consumed.
- s_axis_tdata  in  2·DATA_WIDTH  signed accumulator value.
- m_axis_tdata  out  DATA_WIDTH  signed requantized result.
- m_axis_tuser  out  1  1 = saturation occurred for this result.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream accepts.
- overrun  out  1  sticky; set when a result is dropped because the buffer is full.
- result_count  out  16  number of results accepted downstream; wraps at 2^16.

## Operation
- Beat counter, range 0..N_INPUTS-1, advances on each s_axis_tvalid.
  - On the beat where the counter equals N_INPUTS-1: capture s_axis_tdata into the stage-1 register, set stage-1 valid, wrap the counter to 0.
  - Beats where s_axis_tvalid is low are ignored; the counter holds.
- Stage 2 (requant) runs when stage-1 valid is set:
  - Rounding: r = x + 2^(FRAC_SHIFT-1), computed in 2·DATA_WIDTH+1 bits, so no wrap.
  - Shift: y = r >>> FRAC_SHIFT (arithmetic).
  - Saturation: y > 2^(DATA_WIDTH-1)-1 gives 0x7FF…F; y < -2^(DATA_WIDTH-1) gives 0x800…0. Either case sets the tuser bit.
  - ReLU, applied after saturation when RELU_EN=1: a negative result becomes 0. The tuser bit is kept; it reflects saturation only.
  - The result and its tuser bit are enqueued into a 2-entry FIFO.
- FIFO rules:
  - The head drives m_axis_*; dequeue on m_axis_tvalid && m_axis_tready.
  - Enqueue when full with no dequeue in the same cycle: the new result is dropped and overrun is set.
  - Enqueue and dequeue in the same cycle are always accepted, including when full.
  - Results leave in order.
- result_count increments on each accepted transfer (m_axis_tvalid && m_axis_tready).
- Reset, whether idle or mid-frame, applies:
  - beat counter = 0;
  - stage-1 valid = 0;
  - FIFO emptied;
  - overrun = 0, result_count = 0;
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0.
  - Partial-frame beats received before reset are discarded.

## Timing
- The last beat of a frame is sampled at edge t. Stage-1 is registered at t, the FIFO is written at t+1, and m_axis_tvalid rises after edge t+1. Latency is 2 cycles into an empty FIFO.
- The block sustains one result per frame with N_INPUTS=1 and beats on every cycle, provided m_axis_tready stays high.
- m_axis_tdata and m_axis_tuser are stable while m_axis_tvalid=1 and m_axis_tready=0.
- overrun asserts on the cycle after the drop.

## Structure
- Package nn_pkg: DATA_WIDTH default, the ACC_W = 2·DATA_WIDTH localparam, and saturation constants SAT_MAX and SAT_MIN as functions of width.
- Sub-module requant_sat: combinational round, shift, saturate and ReLU, parameterized by DATA_WIDTH, FRAC_SHIFT and RELU_EN. It is instantiated at stage 2.
- The FIFO is inline: 2 entries with pointers and a count.

## Test plan
All scenarios use DATA_WIDTH=32, N_INPUTS=4, FRAC_SHIFT=16.
- Rounding: 4 beats, last = 64'h0000_0003_0001_8000, ready=1 → 32'h0003_0002, tuser=0. m_axis_tvalid is high 2 cycles after the last beat.
- Positive saturation: last = 64'h0001_0000_0000_0000 → 32'h7FFF_FFFF, tuser=1.
- Negative value, last = 64'hFFFF_FFFF_FFFB_0000:
  - RELU_EN=1 → 32'h0000_0000, tuser=0.
  - RELU_EN=0 → 32'hFFFF_FFFB.
- Backpressure: ready=0 across 3 frames → the first two results are held and the third is dropped, with overrun=1. Then ready=1 → two transfers in order and result_count=2.
- Reset mid-frame: 2 beats, reset for 1 cycle, then 4 beats → exactly one result, equal to the 4th post-reset beat, requantized.
- Simultaneous enqueue and dequeue: FIFO full and ready=1 in the same cycle a new result arrives → no drop, overrun stays 0, and all 3 results are delivered.
